// File: rtl/adder_arbiter_pkg.sv
// rtl/adder_arbiter_pkg.sv - shared adder arbiter types and defaults
//
// Purpose: default operand width and the FSM state encoding shared by
//          adder_arbiter and adder_core.
// Ports:   none (package).
package adder_arbiter_pkg;

  localparam int ADDER_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/adder_core.sv
// rtl/adder_core.sv - combinational unsigned adder with carry-out
//
// Purpose: shared datapath; zero-extends both operands so the carry lands
//          in the top bit of the result.
// Ports:   a, b  WIDTH-bit operands
//          sum   WIDTH+1-bit unsigned sum
module adder_core
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - two-requester round-robin front end to one adder
//
// Purpose: grants one of two requesters in IDLE, adds its operands in EXEC,
//          and holds the result in RESP until the consumer accepts it.
// Ports:   clk, rst_n                      clock, async active-low reset
//          req0_valid/a/b/ready            requester 0 handshake + operands
//          req1_valid/a/b/ready            requester 1 handshake + operands
//          resp_valid/ready, resp_sum/id   result handshake, sum, requester id
//          busy                            high whenever not in IDLE
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH:0]   resp_sum,
  output logic             resp_id,
  output logic             busy
);

  state_t           state_q, state_d;
  logic             last_q;       // requester granted most recently
  logic             id_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH:0]   sum_c, sum_q;
  logic             resp_id_q;
  logic             grant_vld;
  logic             grant_id;
  logic             take;

  // On contention favour the requester that was not granted last; otherwise
  // whichever one is valid wins.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_q;
    end else begin
      grant_id = req1_valid;
    end
  end

  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    resp_valid = 1'b0;
    take       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          take       = 1'b1;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  adder_core #(.WIDTH(WIDTH)) u_adder_core (
    .a   (a_q),
    .b   (b_q),
    .sum (sum_c)
  );

  // The ready is only ever raised while its valid is high, so a grant is
  // always a completed handshake and the pointer can move with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      id_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      resp_id_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        last_q <= grant_id;
        id_q   <= grant_id;
        a_q    <= grant_id ? req1_a : req0_a;
        b_q    <= grant_id ? req1_b : req0_b;
      end
      if (state_q == ST_EXEC) begin
        sum_q     <= sum_c;
        resp_id_q <= id_q;
      end
    end
  end

  assign resp_sum = sum_q;
  assign resp_id  = resp_id_q;

endmodule
